// File: rtl/axi_lite_cfg_apb_bridge.sv
// Single-outstanding AXI4-Lite slave to APB3 master bridge in front of the node configuration register file.
// Optional ACCESS-phase timeout is enabled by defining AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN.
module axi_lite_cfg_apb_bridge #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr_i,
  input  logic                      awvalid_i,
  output logic                      awready_o,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   wstrb_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  output logic [1:0]                bresp_o,
  output logic                      bvalid_o,
  input  logic                      bready_i,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr_i,
  input  logic                      arvalid_i,
  output logic                      arready_o,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic [1:0]                rresp_o,
  output logic                      rvalid_o,
  input  logic                      rready_i,
  output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [DATA_WIDTH-1:0]     PWDATA_o,
  output logic                      PWRITE_o,
  output logic                      PSEL_o,
  output logic                      PENABLE_o,
  input  logic [DATA_WIDTH-1:0]     PRDATA_i,
  input  logic                      PREADY_i,
  input  logic                      PSLVERR_i
);

  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    WRESP,
    RRESP
  } state_t;

  state_t                    state_reg, state_next;
  logic                      rr_last_read_reg, rr_last_read_next;
  logic                      awready_reg, awready_next;
  logic                      wready_reg, wready_next;
  logic                      arready_reg, arready_next;
  logic                      bvalid_reg, bvalid_next;
  logic [1:0]                bresp_reg, bresp_next;
  logic                      rvalid_reg, rvalid_next;
  logic [1:0]                rresp_reg, rresp_next;
  logic [DATA_WIDTH-1:0]     rdata_reg, rdata_next;
  logic [APB_ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0]     pwdata_reg, pwdata_next;
  logic                      pwrite_reg, pwrite_next;
  logic                      psel_reg, psel_next;
  logic                      penable_reg, penable_next;

  logic write_pend;
  logic read_pend;

  assign write_pend = awvalid_i & wvalid_i;
  assign read_pend  = arvalid_i;

`ifdef AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Upper AXI address bits are deliberately dropped; PADDR is the low slice only.
  generate
    if (AXI_ADDR_WIDTH > APB_ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{awaddr_i[AXI_ADDR_WIDTH-1:APB_ADDR_WIDTH],
                                araddr_i[AXI_ADDR_WIDTH-1:APB_ADDR_WIDTH]};
    end
  endgenerate

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg        <= IDLE;
      rr_last_read_reg <= 1'b1;
      awready_reg      <= 1'b0;
      wready_reg       <= 1'b0;
      arready_reg      <= 1'b0;
      bvalid_reg       <= 1'b0;
      bresp_reg        <= RESP_OKAY;
      rvalid_reg       <= 1'b0;
      rresp_reg        <= RESP_OKAY;
      rdata_reg        <= '0;
      paddr_reg        <= '0;
      pwdata_reg       <= '0;
      pwrite_reg       <= 1'b0;
      psel_reg         <= 1'b0;
      penable_reg      <= 1'b0;
`ifdef AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN
      tmo_cnt_reg      <= '0;
`endif
    end else begin
      state_reg        <= state_next;
      rr_last_read_reg <= rr_last_read_next;
      awready_reg      <= awready_next;
      wready_reg       <= wready_next;
      arready_reg      <= arready_next;
      bvalid_reg       <= bvalid_next;
      bresp_reg        <= bresp_next;
      rvalid_reg       <= rvalid_next;
      rresp_reg        <= rresp_next;
      rdata_reg        <= rdata_next;
      paddr_reg        <= paddr_next;
      pwdata_reg       <= pwdata_next;
      pwrite_reg       <= pwrite_next;
      psel_reg         <= psel_next;
      penable_reg      <= penable_next;
`ifdef AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN
      tmo_cnt_reg      <= tmo_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next        = state_reg;
    rr_last_read_next = rr_last_read_reg;
    awready_next      = 1'b0;
    wready_next       = 1'b0;
    arready_next      = 1'b0;
    bvalid_next       = bvalid_reg;
    bresp_next        = bresp_reg;
    rvalid_next       = rvalid_reg;
    rresp_next        = rresp_reg;
    rdata_next        = rdata_reg;
    paddr_next        = paddr_reg;
    pwdata_next       = pwdata_reg;
    pwrite_next       = pwrite_reg;
    psel_next         = psel_reg;
    penable_next      = penable_reg;
`ifdef AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN
    tmo_cnt_next      = tmo_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        // Grant is decided one cycle ahead so the ready pulse itself is registered.
        if (awready_reg) begin
          if (write_pend) begin
            paddr_next  = awaddr_i[APB_ADDR_WIDTH-1:0];
            pwdata_next = wdata_i;
            pwrite_next = 1'b1;
            if (wstrb_i != {STRB_W{1'b1}}) begin
              bvalid_next = 1'b1;
              bresp_next  = RESP_SLVERR;
              state_next  = WRESP;
            end else begin
              psel_next  = 1'b1;
              state_next = SETUP;
            end
          end
        end else if (arready_reg) begin
          if (read_pend) begin
            paddr_next  = araddr_i[APB_ADDR_WIDTH-1:0];
            pwrite_next = 1'b0;
            psel_next   = 1'b1;
            state_next  = SETUP;
          end
        end else if (write_pend && (!read_pend || rr_last_read_reg)) begin
          awready_next = 1'b1;
          wready_next  = 1'b1;
          if (read_pend) begin
            rr_last_read_next = 1'b0;
          end
        end else if (read_pend) begin
          arready_next = 1'b1;
          if (write_pend) begin
            rr_last_read_next = 1'b1;
          end
        end
      end

      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
`ifdef AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN
        tmo_cnt_next = '0;
`endif
      end

      ACCESS: begin
        if (PREADY_i) begin
          psel_next    = 1'b0;
          penable_next = 1'b0;
          if (pwrite_reg) begin
            bvalid_next = 1'b1;
            bresp_next  = PSLVERR_i ? RESP_SLVERR : RESP_OKAY;
            state_next  = WRESP;
          end else begin
            rvalid_next = 1'b1;
            rresp_next  = PSLVERR_i ? RESP_SLVERR : RESP_OKAY;
            rdata_next  = PRDATA_i;
            state_next  = RRESP;
          end
        end
`ifdef AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN
        // This cycle's increment would reach the limit: abandon the transfer.
        else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
          psel_next    = 1'b0;
          penable_next = 1'b0;
          if (pwrite_reg) begin
            bvalid_next = 1'b1;
            bresp_next  = RESP_SLVERR;
            state_next  = WRESP;
          end else begin
            rvalid_next = 1'b1;
            rresp_next  = RESP_SLVERR;
            rdata_next  = '0;
            state_next  = RRESP;
          end
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
`endif
      end

      WRESP: begin
        if (bready_i) begin
          bvalid_next = 1'b0;
          state_next  = IDLE;
        end
      end

      RRESP: begin
        if (rready_i) begin
          rvalid_next = 1'b0;
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign awready_o = awready_reg;
  assign wready_o  = wready_reg;
  assign arready_o = arready_reg;
  assign bvalid_o  = bvalid_reg;
  assign bresp_o   = bresp_reg;
  assign rvalid_o  = rvalid_reg;
  assign rresp_o   = rresp_reg;
  assign rdata_o   = rdata_reg;
  assign PADDR_o   = paddr_reg;
  assign PWDATA_o  = pwdata_reg;
  assign PWRITE_o  = pwrite_reg;
  assign PSEL_o    = psel_reg;
  assign PENABLE_o = penable_reg;

endmodule

// File: tb/tb_axi_lite_cfg_apb_bridge.sv
// Self-checking bench for axi_lite_cfg_apb_bridge: directed cases plus randomized traffic against a
// transaction-level reference model and a behavioural APB slave.
module tb_axi_lite_cfg_apb_bridge;

  localparam int TMO = 16;
`ifdef AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] awaddr_i, wdata_i, araddr_i;
  logic [3:0]  wstrb_i;
  logic        awvalid_i, wvalid_i, bready_i, arvalid_i, rready_i;
  logic        awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
  logic [1:0]  bresp_o, rresp_o;
  logic [31:0] rdata_o, PWDATA_o, PRDATA_i;
  logic [11:0] PADDR_o;
  logic        PWRITE_o, PSEL_o, PENABLE_o, PREADY_i, PSLVERR_i;

  axi_lite_cfg_apb_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .PADDR_o(PADDR_o), .PWDATA_o(PWDATA_o), .PWRITE_o(PWRITE_o), .PSEL_o(PSEL_o),
    .PENABLE_o(PENABLE_o), .PRDATA_i(PRDATA_i), .PREADY_i(PREADY_i), .PSLVERR_i(PSLVERR_i)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected register-file contents and arbitration history.
  logic [31:0] ref_mem [int];
  bit          model_rr_last_read = 1'b1;

  // Behavioural APB slave, steered per transaction by cur_wait / cur_err.
  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [31:0] data;
    int          setups;
    bit          stable;
  } apb_t;
  apb_t        apb_q[$];
  int          cur_wait = 0;
  bit          cur_err  = 1'b0;
  logic [31:0] slave_mem [0:1023];
  int          s_setups = 0;
  int          s_acc    = 0;
  bit          s_stable = 1'b1;
  logic [11:0] s_addr;
  logic        s_wr;
  logic [31:0] s_data;

  initial begin
    apb_t rec;
    for (int i = 0; i < 1024; i++) slave_mem[i] = 32'hC0DE0000 | 32'(i);
    PREADY_i = 1'b0; PSLVERR_i = 1'b0; PRDATA_i = '0;
    forever begin
      @(negedge HCLK);
      if (PSEL_o && !PENABLE_o) begin
        s_setups++; s_acc = 0; s_stable = 1'b1;
        s_addr = PADDR_o; s_wr = PWRITE_o; s_data = PWDATA_o;
        PREADY_i = 1'b0; PSLVERR_i = 1'b0;
      end else if (PSEL_o && PENABLE_o) begin
        if ({PADDR_o, PWRITE_o, PWDATA_o} != {s_addr, s_wr, s_data}) s_stable = 1'b0;
        if (s_acc >= cur_wait) begin
          PREADY_i = 1'b1; PSLVERR_i = cur_err;
          PRDATA_i = PWRITE_o ? 32'h0 : slave_mem[PADDR_o[11:2]];
          rec.addr = PADDR_o; rec.wr = PWRITE_o; rec.data = PWDATA_o;
          rec.setups = s_setups; rec.stable = s_stable;
          apb_q.push_back(rec);
          if (PWRITE_o && !cur_err) slave_mem[PADDR_o[11:2]] = PWDATA_o;
          s_setups = 0;
        end else begin
          PREADY_i = 1'b0; PSLVERR_i = 1'b0; PRDATA_i = $urandom;
        end
        s_acc++;
      end else begin
        PREADY_i = 1'b0; PSLVERR_i = 1'b0; s_setups = 0;
      end
    end
  end

  task automatic expect_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int wait_n, input bit err,
                            output int lat, output logic [1:0] resp, output logic [31:0] rdata,
                            output bit xfer);
    int a;
    a = int'(addr[11:2]);
    rdata = 32'h0;
    if (is_wr && strb != 4'hF) begin
      lat = 1; resp = 2'b10; xfer = 1'b0;
    end else if (TMO_EN && wait_n >= TMO) begin
      lat = 2 + TMO; resp = 2'b10; xfer = 1'b0;
    end else begin
      lat = 3 + wait_n; resp = err ? 2'b10 : 2'b00; xfer = 1'b1;
      if (!is_wr) rdata = ref_mem.exists(a) ? ref_mem[a] : (32'hC0DE0000 | 32'(a));
      if (is_wr && !err) ref_mem[a] = data;
    end
  endtask

  task automatic wait_resp(input bit is_wr, input int n, input int lat, input logic [1:0] resp,
                           input logic [31:0] rdata, input int bp);
    int t;
    bit v;
    t = 0; v = 1'b0;
    while (t < 100) begin
      @(negedge HCLK); t++;
      v = is_wr ? bvalid_o : rvalid_o;
      if (v) break;
    end
    check_val("resp_seen", 64'(v), 64'(1));
    if (!v) return;
    check_val("latency", 64'(cyc - n), 64'(lat));
    check_val("resp", is_wr ? bresp_o : rresp_o, resp);
    if (!is_wr) check_val("rdata", rdata_o, rdata);
    if (bp > 0) begin
      awvalid_i = 1'b1; wvalid_i = 1'b1; wstrb_i = 4'hF; arvalid_i = 1'b1;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge HCLK);
      check_val("bp_hold",
                is_wr ? {bvalid_o, bresp_o, 32'h0, awready_o, arready_o}
                      : {rvalid_o, rresp_o, rdata_o, awready_o, arready_o},
                is_wr ? {1'b1, resp, 32'h0, 2'b00} : {1'b1, resp, rdata, 2'b00});
    end
    if (is_wr) bready_i = 1'b1; else rready_i = 1'b1;
    @(negedge HCLK);
    bready_i = 1'b0; rready_i = 1'b0;
    if (bp > 0) begin
      awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    end
    check_val("post_handshake", {bvalid_o, rvalid_o, awready_o, wready_o, arready_o}, 5'b0);
  endtask

  task automatic check_apb(input bit xfer, input bit is_wr, input logic [31:0] addr,
                           input logic [31:0] data);
    apb_t x;
    check_val("apb_count", 64'(apb_q.size()), xfer ? 64'(1) : 64'(0));
    if (xfer && apb_q.size() > 0) begin
      x = apb_q.pop_front();
      check_val("apb_addr", x.addr, addr[11:0]);
      check_val("apb_write", x.wr, is_wr);
      if (is_wr) check_val("apb_wdata", x.data, data);
      check_val("apb_setup", 64'(x.setups), 64'(1));
      check_val("apb_stable", 64'(x.stable), 64'(1));
    end
    apb_q.delete();
  endtask

  task automatic do_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int wait_n, input bit err, input int bp);
    int t, n, lat;
    logic [1:0]  resp;
    logic [31:0] rd;
    bit xfer;
    cur_wait = wait_n; cur_err = err;
    @(negedge HCLK);
    if (is_wr) begin
      awaddr_i = addr; wdata_i = data; wstrb_i = strb; awvalid_i = 1'b1; wvalid_i = 1'b1;
    end else begin
      araddr_i = addr; arvalid_i = 1'b1;
    end
    t = 0;
    while (t < 50) begin
      @(negedge HCLK); t++;
      if (awready_o || wready_o || arready_o) break;
    end
    check_val("accept", {awready_o, wready_o, arready_o}, is_wr ? 3'b110 : 3'b001);
    if ({awready_o, wready_o, arready_o} != (is_wr ? 3'b110 : 3'b001)) begin
      awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
      return;
    end
    n = cyc;
    expect_txn(is_wr, addr, data, strb, wait_n, err, lat, resp, rd, xfer);
    @(posedge HCLK); #1;
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;
    wait_resp(is_wr, n, lat, resp, rd, bp);
    check_apb(xfer, is_wr, addr, data);
    $display("[TB] txn %s addr=%08h data=%08h strb=%h wait=%0d err=%0d bp=%0d exp_resp=%b",
             is_wr ? "WR" : "RD", addr, data, strb, wait_n, err, bp, resp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, lat;
    logic [1:0]  resp;
    logic [31:0] rd, w_addr, w_data, r_addr, g_addr, g_data;
    bit xfer, exp_w, g_w, saw;

    HRESET = 1'b1;
    awaddr_i = '0; wdata_i = '0; wstrb_i = '0; araddr_i = '0;
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0; bready_i = 1'b0; rready_i = 1'b0;
    repeat (3) @(negedge HCLK);
    check_val("rst_ready", {awready_o, wready_o, arready_o}, 3'b0);
    check_val("rst_valid", {bvalid_o, rvalid_o, bresp_o, rresp_o}, 6'b0);
    check_val("rst_apb_ctl", {PSEL_o, PENABLE_o, PWRITE_o}, 3'b0);
    check_val("rst_apb_data", {PADDR_o, PWDATA_o, rdata_o}, 76'h0);
    HRESET = 1'b0;

    do_txn(1'b1, 32'hA000_0104, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0);
    do_txn(1'b1, 32'h0000_0300, 32'h0000_000F, 4'hF, 0, 1'b0, 0);
    do_txn(1'b0, 32'h0000_0300, 32'h0, 4'hF, 3, 1'b0, 0);

    // Both request kinds held continuously: grants must alternate W,R,W,R.
    cur_wait = 0; cur_err = 1'b0;
    @(negedge HCLK);
    w_addr = 32'h0000_0040 | 32'($urandom_range(0, 7) * 4); w_data = $urandom;
    r_addr = 32'h0000_0040 | 32'($urandom_range(0, 7) * 4);
    awaddr_i = w_addr; wdata_i = w_data; wstrb_i = 4'hF; awvalid_i = 1'b1; wvalid_i = 1'b1;
    araddr_i = r_addr; arvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (t < 50) begin
        @(negedge HCLK); t++;
        if (awready_o || arready_o) break;
      end
      exp_w = model_rr_last_read;
      model_rr_last_read = !exp_w;
      check_val("arb_grant", {awready_o, wready_o, arready_o}, exp_w ? 3'b110 : 3'b001);
      if (!(awready_o || arready_o)) break;
      n = cyc; g_w = awready_o;
      g_addr = g_w ? w_addr : r_addr; g_data = g_w ? w_data : 32'h0;
      expect_txn(g_w, g_addr, g_data, 4'hF, 0, 1'b0, lat, resp, rd, xfer);
      @(posedge HCLK); #1;
      if (g_w) begin
        w_addr = 32'h0000_0040 | 32'($urandom_range(0, 7) * 4); w_data = $urandom;
        awaddr_i = w_addr; wdata_i = w_data;
      end else begin
        r_addr = 32'h0000_0040 | 32'($urandom_range(0, 7) * 4);
        araddr_i = r_addr;
      end
      wait_resp(g_w, n, lat, resp, rd, 0);
      check_apb(xfer, g_w, g_addr, g_data);
      $display("[TB] txn ARB-%s addr=%08h data=%08h", g_w ? "WR" : "RD", g_addr, g_data);
    end
    awvalid_i = 1'b0; wvalid_i = 1'b0; arvalid_i = 1'b0;

    do_txn(1'b0, 32'h0000_0104, 32'h0, 4'hF, 1, 1'b1, 0);
    do_txn(1'b1, 32'h0000_0108, 32'h1234_5678, 4'h3, 0, 1'b0, 0);
    do_txn(1'b0, 32'h0000_0108, 32'h0, 4'hF, 0, 1'b0, 5);

    // Reset while the APB slave is stalling in ACCESS.
    cur_wait = 1000; cur_err = 1'b0;
    @(negedge HCLK);
    araddr_i = 32'h0000_0200; arvalid_i = 1'b1;
    t = 0;
    while (t < 50 && !arready_o) begin @(negedge HCLK); t++; end
    check_val("rst_accept", 64'(arready_o), 64'(1));
    @(posedge HCLK); #1;
    arvalid_i = 1'b0;
    t = 0;
    while (t < 50 && !PENABLE_o) begin @(negedge HCLK); t++; end
    repeat (2) @(negedge HCLK);
    check_val("rst_in_access", {PSEL_o, PENABLE_o}, 2'b11);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    model_rr_last_read = 1'b1;
    check_val("rst_psel", {PSEL_o, PENABLE_o}, 2'b00);
    saw = 1'b0;
    repeat (20) begin
      @(negedge HCLK);
      if (rvalid_o || bvalid_o || PSEL_o) saw = 1'b1;
    end
    check_val("rst_no_resp", 64'(saw), 64'(0));
    apb_q.delete();
    $display("[TB] txn RST-RD addr=00000200 aborted by reset");

`ifdef AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN
    do_txn(1'b0, 32'h0000_0110, 32'h0, 4'hF, 1000, 1'b0, 0);
    do_txn(1'b1, 32'h0000_0114, 32'h5555_AAAA, 4'hF, 1000, 1'b0, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [3:0]  s;
      a = $urandom;
      a[11:2] = 10'h040 + 10'($urandom_range(0, 15));
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
      do_txn(1'($urandom_range(0, 1)), a, $urandom, s, $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_lite_cfg_apb_bridge.md
Name: axi_lite_cfg_apb_bridge

Overview:
- Single-outstanding AXI4-Lite slave to APB3 master bridge.
- Sits directly upstream of the AXI node's APB configuration register file. It converts CPU-side AXI-Lite accesses into APB transfers that program region start/end addresses, valid rules and the connectivity map.
- One transaction is in flight at a time; reads and writes are arbitrated round-robin.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI-Lite address width.
- APB_ADDR_WIDTH, 12, APB address width; PADDR = low bits of the AXI address.
- DATA_WIDTH, 32, data width on both sides; only 32 is supported.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles. Used only with APB_TIMEOUT_EN.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  synchronous, active-high reset
- awaddr_i  in  AXI_ADDR_WIDTH  write address
- awvalid_i / awready_o  in/out  1  AW handshake
- wdata_i  in  DATA_WIDTH  write data
- wstrb_i  in  DATA_WIDTH/8  write strobes
- wvalid_i / wready_o  in/out  1  W handshake
- bresp_o  out  2  write response
- bvalid_o / bready_i  out/in  1  B handshake
- araddr_i  in  AXI_ADDR_WIDTH  read address
- arvalid_i / arready_o  in/out  1  AR handshake
- rdata_o  out  DATA_WIDTH  read data
- rresp_o  out  2  read response
- rvalid_o / rready_i  out/in  1  R handshake
- PADDR_o  out  APB_ADDR_WIDTH  APB address
- PWDATA_o  out  DATA_WIDTH  APB write data
- PWRITE_o, PSEL_o, PENABLE_o  out  1  APB control
- PRDATA_i  in  DATA_WIDTH  APB read data
- PREADY_i, PSLVERR_i  in  1  APB completion / error

Behaviour:
- **FSM states:** IDLE, SETUP, ACCESS, WRESP, RRESP. All outputs are registered.
- **Reset values:** all valids/readies, PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA, rdata, bresp, rresp = 0; state = IDLE; rr_last = read.
- **IDLE, request eligibility:** a write is pending only when awvalid and wvalid are both high. A read is pending when arvalid is high.
- **IDLE, arbitration:** if only one kind is pending, it is granted. If both are pending, grant the kind opposite to rr_last, then update rr_last.
- **IDLE, accept:** awready and wready pulse together for exactly one cycle on write grant; arready pulses for one cycle on read grant.
- **IDLE, latching:** address, data and direction are latched on the accept cycle.
- **Partial strobe:** a write grant with wstrb != all-ones issues no APB transfer and goes directly to WRESP with bresp = 2'b10.
- **SETUP:** PSEL=1, PENABLE=0 for exactly one cycle. PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.
- **ACCESS:** PSEL=1, PENABLE=1 until PREADY_i=1. On that cycle:
  - PRDATA_i is captured into rdata_o.
  - PSLVERR_i maps to resp 2'b10; otherwise resp = 2'b00.
  - Next state is WRESP or RRESP. PSEL and PENABLE drop the following cycle.
- **Minimum latency:** accept at cycle N; SETUP at N+1; ACCESS at N+2 (with PREADY=1); bvalid/rvalid at N+3.
- **WRESP / RRESP:** bvalid or rvalid is held with stable data/resp until the matching ready is high, then return to IDLE. No accept happens in the same cycle as the response handshake, so back-to-back transactions are spaced by at least 1 IDLE cycle.
- **Address handling:** address bits above APB_ADDR_WIDTH are ignored. AXI awprot/arprot are not supported.
- **Reset mid-operation:** HRESET forces IDLE at the next edge. PSEL drops, and any pending response is discarded without being issued.

Optional Feature:
- **Macro:** AXI_LITE_CFG_APB_BRIDGE_APB_TIMEOUT_EN.
- **With the macro:** a counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY. When it reaches TIMEOUT_CYCLES, the transfer is aborted: PSEL/PENABLE drop, resp = 2'b10, rdata = 0, and the FSM moves to the response state.
- **Without the macro:** ACCESS waits indefinitely for PREADY, and no counter logic is present.

Test Plan:
- **Single write:** AW+W to 0x104 with data 0xDEADBEEF, wstrb=4'hF, PREADY=1 → exactly one APB cycle pair with PADDR=0x104 and PWRITE=1; bvalid at accept+3 with bresp=00.
- **Single read:** AR to 0x300, PRDATA=0x0000000F, PREADY held 0 for 3 ACCESS cycles → rvalid with rdata=0x0000000F, rresp=00; PSEL held continuously through ACCESS.
- **Simultaneous requests:** read and write both valid in IDLE for 4 consecutive transactions → grants alternate W,R,W,R (rr_last starts as read).
- **Error and strobe paths:** PSLVERR=1 on a read → rresp=10. A write with wstrb=4'h3 → no PSEL, bresp=10.
- **Back-pressure:** rready=0 for 5 cycles → rvalid and rdata stable; no new arready during that time; IDLE follows the handshake.
- **Reset and timeout:** HRESET asserted during ACCESS → PSEL=0 and no response after reset. With the macro and PREADY stuck 0, TIMEOUT_CYCLES=16 → rvalid 16 cycles after ACCESS entry, rresp=10.
